// File: rtl/fifo_narrow_to_wide.sv
// fifo_narrow_to_wide
// Synchronous FIFO: one DATA_WIDTH word in per write, one 2*DATA_WIDTH word
// (two oldest narrow words, oldest in the low half) out per read.
// Storage, pointers, occupancy counter and registered status flags are local.
// The output pair is shown ahead: it is valid whenever empty_o is low.

module fifo_narrow_to_wide #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    write_i,
  input  logic [DATA_WIDTH-1:0]   write_data_i,
  input  logic                    read_i,
  output logic [2*DATA_WIDTH-1:0] read_data_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic [ADDR_WIDTH:0]     count_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Occupancy levels used for flag generation.
  localparam logic [ADDR_WIDTH:0] full_level = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] pair_level = (ADDR_WIDTH + 1)'(2'd2);

  // Pointer steps; the read side always consumes a whole pair.
  localparam logic [ADDR_WIDTH-1:0] wr_step = (ADDR_WIDTH)'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] rd_step = (ADDR_WIDTH)'(2'd2);
  localparam logic [ADDR_WIDTH-1:0] odd_off = (ADDR_WIDTH)'(1'b1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr_odd;
  logic [ADDR_WIDTH:0]   count;
  logic                  empty_flag;
  logic                  full_flag;

  logic                  write_accept;
  logic                  read_accept;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  empty_next;
  logic                  full_next;

  // Request gating, next occupancy and next flag values.
  always_comb begin
    write_accept = 1'b0;
    read_accept  = 1'b0;
    count_next   = count;
    empty_next   = empty_flag;
    full_next    = full_flag;

    // Each side is qualified only by its own registered flag, so a full
    // FIFO still honours a read and a one-word FIFO still honours a write.
    write_accept = write_i && !full_flag;
    read_accept  = read_i && !empty_flag;

    count_next = count
               + (ADDR_WIDTH + 1)'(write_accept)
               - (ADDR_WIDTH + 1)'({read_accept, 1'b0});

    if (count_next < pair_level) begin
      empty_next = 1'b1;
    end else begin
      empty_next = 1'b0;
    end

    if (count_next == full_level) begin
      full_next = 1'b1;
    end else begin
      full_next = 1'b0;
    end
  end

  // Storage: cleared on reset, one narrow word written per accepted write.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_accept) begin
      mem[wr_ptr] <= write_data_i;
    end
  end

  // Write pointer: one narrow slot per accepted write, natural wrap.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_ptr <= '0;
    end else if (write_accept) begin
      wr_ptr <= wr_ptr + wr_step;
    end
  end

  // Read pointer: stays even, advances one pair per accepted read.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      rd_ptr <= '0;
    end else if (read_accept) begin
      rd_ptr <= rd_ptr + rd_step;
    end
  end

  // Occupancy counter and registered status flags.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      count      <= '0;
      empty_flag <= 1'b1;
      full_flag  <= 1'b0;
    end else begin
      count      <= count_next;
      empty_flag <= empty_next;
      full_flag  <= full_next;
    end
  end

  // Upper half of the head pair; rd_ptr is even so this never wraps into it.
  always_comb begin
    rd_ptr_odd = rd_ptr + odd_off;
  end

  // Show-ahead head pair, older word in the low half.
  always_comb begin
    read_data_o = {mem[rd_ptr_odd], mem[rd_ptr]};
  end

  // Status outputs straight from their registers.
  always_comb begin
    empty_o = empty_flag;
    full_o  = full_flag;
    count_o = count;
  end

endmodule

// File: tb/tb_fifo_narrow_to_wide.sv
// Bench for fifo_narrow_to_wide (DATA_WIDTH=8, ADDR_WIDTH=3, depth 8).
// A queue of narrow words models the FIFO contents; a negedge process
// compares the DUT status and head pair against it every cycle, and the
// directed sequence adds hand-computed literal expectations.

module tb_fifo_narrow_to_wide;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic          clk_i = 1'b0;
  logic          reset_ni;
  logic          write_i;
  logic [DW-1:0] write_data_i;
  logic          read_i;
  logic [2*DW-1:0] read_data_o;
  logic          empty_o;
  logic          full_o;
  logic [AW:0]   count_o;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] q [$];
  bit model_on = 1'b0;

  fifo_narrow_to_wide #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .write_i      (write_i),
    .write_data_i (write_data_i),
    .read_i       (read_i),
    .read_data_o  (read_data_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .count_o      (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, apply the FIFO rules to the queue.
  task automatic step(input logic rst_n, input logic w, input logic [DW-1:0] wd, input logic r);
    bit do_r;
    bit do_w;
    reset_ni = rst_n;
    write_i = w;
    write_data_i = wd;
    read_i = r;
    do_r = r && (q.size() >= 2);
    do_w = w && (q.size() < DEPTH);
    @(posedge clk_i);
    if (!rst_n) begin
      q.delete();
    end else begin
      if (do_r) begin
        void'(q.pop_front());
        void'(q.pop_front());
      end
      if (do_w) q.push_back(wd);
    end
    model_on = 1'b1;
    #1;
    write_i = 1'b0;
    read_i = 1'b0;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    step(1'b1, 1'b1, d, 1'b0);
  endtask

  task automatic rd();
    step(1'b1, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic rst1();
    step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Every-cycle comparison against the queue model.
  always @(negedge clk_i) begin
    if (model_on) begin
      check("model_count", 32'(count_o), 32'(q.size()));
      check("model_empty", 32'(empty_o), 32'(q.size() < 2));
      check("model_full", 32'(full_o), 32'(q.size() == DEPTH));
      if (q.size() >= 2) begin
        check("model_rdata", 32'(read_data_o), 32'({q[1], q[0]}));
      end
    end
  end

  initial begin
    reset_ni = 1'b0;
    write_i = 1'b0;
    write_data_i = 8'h00;
    read_i = 1'b0;

    // 1. reset held two cycles, a write pulse inside it is ignored
    rst1();
    step(1'b0, 1'b1, 8'h77, 1'b0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_rdata", 32'(read_data_o), 32'h0000);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("rel_count", 32'(count_o), 32'd0);
    check("rel_rdata", 32'(read_data_o), 32'h0000);

    // 2. single pair
    wr(8'h11);
    check("one_count", 32'(count_o), 32'd1);
    check("one_empty", 32'(empty_o), 32'd1);
    wr(8'h22);
    check("two_count", 32'(count_o), 32'd2);
    check("two_empty", 32'(empty_o), 32'd0);
    check("two_rdata", 32'(read_data_o), 32'h2211);
    rd();
    check("rd2_count", 32'(count_o), 32'd0);
    check("rd2_empty", 32'(empty_o), 32'd1);

    // 3. fill, overflow, drain, underflow
    for (int i = 1; i <= 8; i++) wr(8'(i));
    check("fill_full", 32'(full_o), 32'd1);
    check("fill_count", 32'(count_o), 32'd8);
    wr(8'hFF);
    check("ovf_count", 32'(count_o), 32'd8);
    check("drain0", 32'(read_data_o), 32'h0201);
    rd();
    check("drain1", 32'(read_data_o), 32'h0403);
    rd();
    check("drain2", 32'(read_data_o), 32'h0605);
    rd();
    check("drain3", 32'(read_data_o), 32'h0807);
    rd();
    check("drain_empty", 32'(empty_o), 32'd1);
    rd();
    check("udf_count", 32'(count_o), 32'd0);

    // 4. wrap-around from pointers at zero
    rst1();
    for (int i = 0; i < 6; i++) wr(8'hA0 + 8'(i));
    check("wrap_a0", 32'(read_data_o), 32'hA1A0);
    rd();
    check("wrap_a1", 32'(read_data_o), 32'hA3A2);
    rd();
    check("wrap_a2", 32'(read_data_o), 32'hA5A4);
    rd();
    for (int i = 0; i < 4; i++) wr(8'hB0 + 8'(i));
    check("wrap_b0", 32'(read_data_o), 32'hB1B0);
    rd();
    check("wrap_b1", 32'(read_data_o), 32'hB3B2);
    rd();
    check("wrap_count", 32'(count_o), 32'd0);

    // 5a. count=3 with both requests
    wr(8'h31); wr(8'h32); wr(8'h33);
    check("sim3_pre", 32'(read_data_o), 32'h3231);
    step(1'b1, 1'b1, 8'h34, 1'b1);
    check("sim3_count", 32'(count_o), 32'd2);
    check("sim3_rdata", 32'(read_data_o), 32'h3433);
    rd();

    // 5b. full with both requests: read wins, write dropped
    for (int i = 0; i < 8; i++) wr(8'hC0 + 8'(i));
    step(1'b1, 1'b1, 8'hEE, 1'b1);
    check("simf_count", 32'(count_o), 32'd6);
    check("simf_full", 32'(full_o), 32'd0);
    check("simf_rdata", 32'(read_data_o), 32'hC3C2);
    rd(); rd(); rd();
    check("simf_drain", 32'(count_o), 32'd0);

    // 5c. count=1 with both requests: write wins, read ignored
    wr(8'h41);
    step(1'b1, 1'b1, 8'h42, 1'b1);
    check("sim1_count", 32'(count_o), 32'd2);
    check("sim1_empty", 32'(empty_o), 32'd0);
    check("sim1_rdata", 32'(read_data_o), 32'h4241);
    rd();

    // 6. reset mid-operation discards contents
    for (int i = 0; i < 5; i++) wr(8'h50 + 8'(i));
    check("mid_count5", 32'(count_o), 32'd5);
    rst1();
    check("mid_count", 32'(count_o), 32'd0);
    check("mid_empty", 32'(empty_o), 32'd1);
    check("mid_full", 32'(full_o), 32'd0);
    check("mid_rdata", 32'(read_data_o), 32'h0000);
    wr(8'h55); wr(8'h66);
    check("post_rdata", 32'(read_data_o), 32'h6655);
    step(1'b1, 1'b0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
